// File: rtl/readout_sequencer_pkg.sv
// Shared types and default geometry for the pixel readout sequencer and the
// row-select shifter it drives.
package readout_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ERASE   = 3'd1,
        EXPOSE  = 3'd2,
        CONVERT = 3'd3,
        READ    = 3'd4,
        ADVANCE = 3'd5,
        DONE    = 3'd6
    } seq_state_t;

    localparam int DEF_ROWS         = 4;
    localparam int DEF_ERASE_CYCLES = 2;
    localparam int DEF_CONV_CYCLES  = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/readout_sequencer_phase_timer.sv
// Loadable down-counter that parks at zero; a phase of N cycles is timed by
// loading N-1 on entry and leaving the phase on the cycle where zero is high.
module phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/readout_sequencer.sv
// Frame sequencer: erase, expose and convert the pixel array, then hand rows
// one at a time to the readout consumer while stepping the row-select shifter.
//
//   state   | meaning
//   IDLE    | waiting for start
//   ERASE   | pixel reset, shifter forced to row 0 in the first cycle
//   EXPOSE  | integration for max(exposure,1) cycles
//   CONVERT | ADC / compare phase
//   READ    | current row offered to the consumer
//   ADVANCE | shifter steps to the next row
//   DONE    | one-cycle frame-complete pulse
module readout_sequencer
    import readout_pkg::*;
#(
    parameter int ROWS         = DEF_ROWS,
    parameter int EXP_W        = 8,
    parameter int ERASE_CYCLES = DEF_ERASE_CYCLES,
    parameter int CONV_CYCLES  = DEF_CONV_CYCLES,
    parameter int ROW_W        = max_int($clog2(ROWS), 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [EXP_W-1:0] exposure,
    output logic             busy,
    output logic             done,
    output logic             pix_erase,
    output logic             pix_expose,
    output logic             pix_convert,
    output logic             row_rst,
    output logic             row_advance,
    output logic             row_out_en,
    output logic [ROW_W-1:0] row_index,
    output logic             sample_valid,
    input  logic             sample_ready
);

    localparam int TIMER_W = max_int(EXP_W,
                             max_int($clog2(ERASE_CYCLES), $clog2(CONV_CYCLES)));
    localparam logic [TIMER_W-1:0] ERASE_LOAD = TIMER_W'(ERASE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] CONV_LOAD  = TIMER_W'(CONV_CYCLES - 1);
    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(ROWS - 1);

    seq_state_t         state;
    seq_state_t         state_next;
    logic [EXP_W-1:0]   exposure_q;
    logic [EXP_W-1:0]   exposure_next;
    logic [ROW_W-1:0]   row_next;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_zero;
    logic [TIMER_W-1:0] expose_load;
    logic               row_rst_q;

    phase_timer #(.W(TIMER_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .value (timer_value),
        .zero  (timer_zero)
    );

    // exposure 0 still integrates for one cycle; 255 loads 254 and never wraps
    assign expose_load = (exposure_q == '0) ? '0 : TIMER_W'(exposure_q) - TIMER_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            exposure_q <= '0;
            row_index  <= '0;
            row_rst_q  <= 1'b0;
        end else begin
            state      <= state_next;
            exposure_q <= exposure_next;
            row_index  <= row_next;
            row_rst_q  <= (state_next == ERASE) && (state != ERASE);
        end
    end

    always_comb begin
        state_next    = state;
        exposure_next = exposure_q;
        row_next      = row_index;
        timer_load    = 1'b0;
        timer_value   = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next    = ERASE;
                    exposure_next = exposure;
                    timer_load    = 1'b1;
                    timer_value   = ERASE_LOAD;
                end
            end
            ERASE: begin
                row_next = '0;
                if (timer_zero) begin
                    state_next  = EXPOSE;
                    timer_load  = 1'b1;
                    timer_value = expose_load;
                end
            end
            EXPOSE: begin
                if (timer_zero) begin
                    state_next  = CONVERT;
                    timer_load  = 1'b1;
                    timer_value = CONV_LOAD;
                end
            end
            CONVERT: begin
                if (timer_zero) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (sample_ready) begin
                    state_next = (row_index == LAST_ROW) ? DONE : ADVANCE;
                end
            end
            ADVANCE: begin
                state_next = READ;
                row_next   = row_index + ROW_W'(1);
            end
            DONE: begin
                state_next = IDLE;
                row_next   = '0;
            end
            default: begin
                state_next = IDLE;
                row_next   = '0;
            end
        endcase
    end

    // row_rst feeds the shifter's async reset, so it comes straight from a flop
    assign row_rst      = row_rst_q;
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign pix_erase    = (state == ERASE);
    assign pix_expose   = (state == EXPOSE);
    assign pix_convert  = (state == CONVERT);
    assign row_advance  = (state == ADVANCE);
    assign row_out_en   = (state == READ) || (state == ADVANCE);
    assign sample_valid = (state == READ);

endmodule

// File: doc/readout_sequencer.md
Name: readout_sequencer

Overview:
- Frame-level control FSM for the pixel array.
- Sits directly upstream of the circular row-select shifter and drives its input-enable (`row_advance`), output-enable (`row_out_en`) and reset (`row_rst`) pins.
- Also sequences the pixel erase, expose and convert phases.
- Presents one row at a time to the downstream readout consumer via a valid/ready handshake.

Parameters:
- `ROWS`, 4, number of pixel rows; must equal the shifter length.
- `EXP_W`, 8, width of the exposure-time input.
- `ERASE_CYCLES`, 2, cycles `pix_erase` is held high (≥1).
- `CONV_CYCLES`, 3, cycles `pix_convert` is held high (≥1).
- `ROW_W`, $clog2(ROWS) (min 1), width of `row_index`.

Ports:
- `clk` input 1: clock, rising-edge.
- `reset` input 1: reset, asynchronous, active-high.
- `start` input 1: frame request, sampled in IDLE only.
- `exposure` input EXP_W: exposure length in cycles, latched on accepted `start`.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when the frame completes.
- `pix_erase` output 1: pixel reset phase.
- `pix_expose` output 1: integration phase.
- `pix_convert` output 1: ADC/compare phase.
- `row_rst` output 1: to shifter reset; forces row 0.
- `row_advance` output 1: to shifter inputEnable; one-cycle pulse.
- `row_out_en` output 1: to shifter outputEnable.
- `row_index` output ROW_W: binary index of the row currently selected.
- `sample_valid` output 1: current row ready for the consumer.
- `sample_ready` input 1: consumer accepts the current row.

Behaviour:
- All outputs are Moore-decoded from registered state/counters; none depends combinationally on inputs. This is required because `row_rst` drives an async reset.
- Reset, asynchronous, any time including mid-frame:
  - state = IDLE, counters = 0, `row_index` = 0.
  - All outputs 0.
  - The latched exposure value clears to 0.
- IDLE:
  - `start` = 1 → latch `exposure`; go to ERASE with counter = 0.
  - `start` while not IDLE is ignored; there is no queuing.
- ERASE:
  - `pix_erase` = 1 for ERASE_CYCLES cycles.
  - `row_rst` = 1 only in the first ERASE cycle.
  - `row_index` ← 0.
  - Then → EXPOSE.
- EXPOSE:
  - `pix_expose` = 1 for max(exposure, 1) cycles; exposure 0 is treated as 1.
  - Counter is EXP_W wide; exposure 255 gives exactly 255 cycles, with no wrap.
  - Then → CONVERT.
- CONVERT:
  - `pix_convert` = 1 for CONV_CYCLES cycles.
  - Then → READ.
- READ:
  - `row_out_en` = 1 and `sample_valid` = 1.
  - Stays in READ while `sample_ready` = 0; `sample_valid` is held and `row_index` is stable.
  - On a cycle with valid & ready:
    - If `row_index` == ROWS-1 → DONE.
    - Otherwise → ADVANCE.
- ADVANCE (1 cycle):
  - `row_advance` = 1 and `row_out_en` = 1; `sample_valid` = 0.
  - `row_index` increments at the end of the cycle, in step with the shifter shift.
  - Then → READ.
- DONE (1 cycle):
  - `done` = 1; `busy` still 1.
  - Then → IDLE; `row_index` returns to 0.
- Latency: for a frame with no back-pressure, `start` to `done` = 1 + ERASE_CYCLES + max(exp,1) + CONV_CYCLES + (2·ROWS − 1) cycles, from the `start` edge to the `done`-high cycle.
- The `row_index` counter never wraps inside a frame; ADVANCE is never entered on the last row.
- `start` high in the DONE cycle is ignored. `start` high in the following IDLE cycle is accepted, so back-to-back frames have one IDLE cycle between them.
- Exactly one of `pix_erase`, `pix_expose` or `pix_convert` is high at a time, or none.
- `row_advance` and `sample_valid` are never high together.

Decomposition:
- Shared package `readout_pkg`:
  - Enum `seq_state_t` {IDLE, ERASE, EXPOSE, CONVERT, READ, ADVANCE, DONE}, 3-bit encoding.
  - Default constants for ROWS, ERASE_CYCLES and CONV_CYCLES, shared with the shifter instantiation.
- Sub-module `phase_timer`:
  - Loadable down-counter with a `zero` flag.
  - Reused for the ERASE, EXPOSE and CONVERT durations.
  - The FSM and the row counter stay in the top module.

Test Plan:
- Basic frame, ROWS=4, exposure=5, `sample_ready` tied 1:
  - `pix_erase` high 2 cycles, `pix_expose` high 5 cycles, `pix_convert` high 3 cycles.
  - `sample_valid` pulses at `row_index` 0, 1, 2, 3; `row_advance` fires 3 times.
  - `done` arrives exactly 18 cycles after `start`.
- Back-pressure:
  - Hold `sample_ready` = 0 for 4 cycles on row 2.
  - `sample_valid` stays 1, `row_index` stays 2, and `row_advance` stays 0 throughout.
  - Release → ADVANCE, then row 3.
- Exposure 0:
  - `pix_expose` is high exactly 1 cycle.
  - Exposure 255 gives exactly 255 cycles.
- Reset mid-operation:
  - Assert `reset` asynchronously mid-EXPOSE and again mid-READ on row 1.
  - All outputs go to 0 immediately without waiting for a `clk` edge; `busy` = 0 and `row_index` = 0.
  - The next `start` gives a full, correct frame.
- `start` while busy:
  - Pulse `start` during CONVERT and in the DONE cycle; there is no second frame.
  - `start` held continuously gives frames separated by exactly one IDLE cycle.
- Integration with the shifter (length 4):
  - Its `out` equals 1 << `row_index` in every READ cycle.
  - Its `out` is 4'b0001 after every ERASE.
